regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (we3/wa3/wd3) between the main
//  pipeline writeback (primary) and a multi-cycle unit such as mul/ldm (secondary).
//  Primary always wins. Secondary results queue in a small FIFO.
//  A starvation counter forces a pipeline stall so that queued results drain.
//  A 15-bit scoreboard marks registers with an outstanding secondary write, for
//  use by the hazard unit.
// PARAMETERS
//  DEPTH      2   secondary FIFO entries (>=1)
//  STARVE_MAX 4   cycles the FIFO head may wait before stall_req asserts (>=1)
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  reset_n    in   1   asynchronous, active-low reset
//  p_we       in   1   primary writeback enable
//  p_wa       in   4   primary destination register
//  p_wd       in   32  primary write data
//  s_valid    in   1   secondary result valid
//  s_wa       in   4   secondary destination register
//  s_wd       in   32  secondary write data
//  s_ready    out  1   FIFO can accept; push = s_valid & s_ready
//  s_claim    in   1   secondary op issued; reserve s_claim_ra
//  s_claim_ra in   4   register reserved by s_claim
//  we3        out  1   to RegFile write enable (registered)
//  wa3        out  4   to RegFile write address (registered)
//  wd3        out  32  to RegFile write data (registered)
//  busy       out  15  busy[r]=1: secondary write to r is pending
//  stall_req  out  1   pipeline must hold p_we=0 while high (registered)
//  waw_err    out  1   1-cycle pulse: primary wrote a busy register
// BEHAVIOUR
//  Reset: we3=0, wa3=0, wd3=0, busy=0, stall_req=0, waw_err=0.
//   FIFO is empty, so s_ready=1. Starve counter=0. FSM=IDLE.
//  s_ready = (count < DEPTH), combinational from count only.
//  Select, per cycle c (result appears on we3/wa3/wd3 in cycle c+1):
//   - p_we=1 and p_wa!=15: grant primary.
//   - else FIFO non-empty: grant and pop the head.
//   - else: we3=0 next cycle. wa3/wd3 hold their last value.
//  Any entry with wa=15 never drives we3; r15 belongs to the PC path.
//   Primary: ignored. Secondary: popped and discarded in its grant slot.
//  A pushed result becomes head the cycle after the push.
//   Minimum push-to-we3 latency is 2 cycles.
//  Push and pop in the same cycle: count unchanged. Head/tail pointers wrap modulo DEPTH.
//  A push while full cannot occur, because s_ready=0.
//  FSM states:
//   - IDLE (empty) -> PEND on push.
//   - PEND (non-empty):
//     - starve counter +1 on each cycle the head is not granted; clears on a head pop.
//     - -> FORCE when the counter reaches STARVE_MAX.
//     - -> IDLE when the last entry pops.
//   - FORCE: stall_req=1, counter held, secondary granted every cycle.
//     - -> IDLE when empty, or -> PEND with counter=0 when the count drops below DEPTH.
//  p_we=1 during FORCE is a protocol violation. Primary still wins; assertion fires.
//  Scoreboard:
//   - s_claim sets busy[s_claim_ra] (ignored for ra=15).
//   - A secondary grant clears busy[wa] in the select cycle.
//   - Claim and clear of the same register in one cycle: set wins.
//  waw_err pulses in cycle c+1 if p_we=1 && p_wa!=15 && busy[p_wa] in cycle c.
//  Reset asserted mid-operation: the FIFO is flushed and all outputs return to reset values
//   immediately. No write issues after reset is asserted.
// TESTING
//  1. Primary only: p_we=1,p_wa=3,p_wd=32'hA5A5_0001 in cycle 0
//     -> we3=1,wa3=3,wd3=A5A5_0001 in cycle 1. Then we3=0.
//  2. Secondary into an idle port: push wa=7,wd=32'h0000_0042 at edge 0
//     -> we3=1,wa3=7 in cycle 2. busy[7] clears in cycle 2.
//  3. Collision: p_we=1 (wa=1) and FIFO head wa=2 in the same cycle
//     -> primary written first, secondary the next free cycle. Starve counter=1.
//  4. Starvation: FIFO full (DEPTH=2) with p_we=1 every cycle
//     -> stall_req=1 after 4 waiting cycles. Both entries write on consecutive cycles.
//     -> stall_req drops. s_ready=1.
//  5. r15 filter + scoreboard: p_wa=15 -> no we3. s_claim ra=15 -> busy unchanged.
//     s_claim ra=5, then p_we wa=5 -> waw_err pulse one cycle later.
//  6. Reset asserted mid-drain with 2 entries queued
//     -> we3=0, busy=0, s_ready=1 immediately. No stale write after release.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between primary writeback and a queued secondary unit
module regfile_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p_we,
  input  logic [3:0]  p_wa,
  input  logic [31:0] p_wd,
  input  logic        s_valid,
  input  logic [3:0]  s_wa,
  input  logic [31:0] s_wd,
  output logic        s_ready,
  input  logic        s_claim,
  input  logic [3:0]  s_claim_ra,
  output logic        we3,
  output logic [3:0]  wa3,
  output logic [31:0] wd3,
  output logic [14:0] busy,
  output logic        stall_req,
  output logic        waw_err
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;
  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    fifo_wa_q [DEPTH];
  logic [31:0]   fifo_wd_q [DEPTH];
  logic          we3_q, we3_d, stall_q, stall_d, waw_q, waw_d;
  logic [3:0]    wa3_q, wa3_d;
  logic [31:0]   wd3_q, wd3_d;
  logic [14:0]   busy_q, busy_d;
  logic [15:0]   busy_x;
  logic [3:0]    head_wa;
  logic [31:0]   head_wd;
  logic          grant_p, pop, push;
  assign s_ready   = count_q < CW'(DEPTH);
  assign we3       = we3_q;
  assign wa3       = wa3_q;
  assign wd3       = wd3_q;
  assign busy      = busy_q;
  assign stall_req = stall_q;
  assign waw_err   = waw_q;
  assign busy_x    = {1'b0, busy_q};
  assign head_wa   = fifo_wa_q[head_q];
  assign head_wd   = fifo_wd_q[head_q];
  // r15 belongs to the PC path: primary writes to it are dropped, secondary ones drain silently
  always_comb begin
    grant_p = p_we && p_wa != 4'd15;
    pop     = !grant_p && count_q != '0;
    push    = s_valid && s_ready;
    we3_d   = grant_p || (pop && head_wa != 4'd15);
    wa3_d   = grant_p ? p_wa : (we3_d ? head_wa : wa3_q);
    wd3_d   = grant_p ? p_wd : (we3_d ? head_wd : wd3_q);
    waw_d   = grant_p && busy_x[p_wa];
    count_d = count_q + CW'(push) - CW'(pop);
    head_d  = pop ? (head_q == PW'(DEPTH - 1) ? '0 : head_q + PW'(1)) : head_q;
    tail_d  = push ? (tail_q == PW'(DEPTH - 1) ? '0 : tail_q + PW'(1)) : tail_q;
    busy_d  = busy_q;
    if (pop && head_wa != 4'd15) busy_d[head_wa] = 1'b0;
    if (s_claim && s_claim_ra != 4'd15) busy_d[s_claim_ra] = 1'b1;
  end
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        starve_d = '0;
        if (push) state_d = PEND;
      end
      PEND: begin
        if (count_d == '0) begin
          state_d  = IDLE;
          starve_d = '0;
        end else if (pop) begin
          starve_d = '0;
        end else begin
          starve_d = starve_q + SW'(1);
          if (starve_d == SW'(STARVE_MAX)) state_d = FORCE;
        end
      end
      FORCE: begin
        if (count_d == '0) begin
          state_d  = IDLE;
          starve_d = '0;
        end else if (count_d < CW'(DEPTH)) begin
          state_d  = PEND;
          starve_d = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        starve_d = '0;
      end
    endcase
    stall_d = state_d == FORCE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      we3_q    <= 1'b0;
      wa3_q    <= '0;
      wd3_q    <= '0;
      busy_q   <= '0;
      stall_q  <= 1'b0;
      waw_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      we3_q    <= we3_d;
      wa3_q    <= wa3_d;
      wd3_q    <= wd3_d;
      busy_q   <= busy_d;
      stall_q  <= stall_d;
      waw_q    <= waw_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wa_q[tail_q] <= s_wa;
      fifo_wd_q[tail_q] <= s_wd;
    end
  end
  assert property (@(posedge clk) disable iff (!reset_n) stall_q |-> !p_we);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenario tests for the write-port arbiter
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        p_we, s_valid, s_claim;
  logic [3:0]  p_wa, s_wa, s_claim_ra;
  logic [31:0] p_wd, s_wd;
  logic        s_ready, we3, stall_req, waw_err;
  logic [3:0]  wa3;
  logic [31:0] wd3;
  logic [14:0] busy;
  int checks = 0;
  int failures = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .p_we(p_we), .p_wa(p_wa), .p_wd(p_wd),
    .s_valid(s_valid), .s_wa(s_wa), .s_wd(s_wd), .s_ready(s_ready),
    .s_claim(s_claim), .s_claim_ra(s_claim_ra),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .busy(busy), .stall_req(stall_req), .waw_err(waw_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    p_we = 0; p_wa = 0; p_wd = 0;
    s_valid = 0; s_wa = 0; s_wd = 0;
    s_claim = 0; s_claim_ra = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 0;
    tick();
    checks++; if (we3 !== 1'b0) begin failures++; $display("FAIL reset_we3 got=%b exp=0", we3); end
    checks++; if (wa3 !== 4'd0) begin failures++; $display("FAIL reset_wa3 got=%h exp=0", wa3); end
    checks++; if (wd3 !== 32'd0) begin failures++; $display("FAIL reset_wd3 got=%h exp=0", wd3); end
    checks++; if (busy !== 15'd0) begin failures++; $display("FAIL reset_busy got=%h exp=0", busy); end
    checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
    checks++; if (waw_err !== 1'b0) begin failures++; $display("FAIL reset_waw got=%b exp=0", waw_err); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
    reset_n = 1;
    tick();
  endtask

  task automatic test_primary();
    p_we = 1; p_wa = 4'd3; p_wd = 32'hA5A5_0001;
    tick();
    clear_inputs();
    checks++; if ({we3, wa3, wd3} !== {1'b1, 4'd3, 32'hA5A5_0001}) begin failures++; $display("FAIL primary_write got=%b/%h/%h exp=1/3/a5a50001", we3, wa3, wd3); end
    tick();
    checks++; if (we3 !== 1'b0) begin failures++; $display("FAIL primary_idle_we3 got=%b exp=0", we3); end
    checks++; if (wa3 !== 4'd3) begin failures++; $display("FAIL primary_hold_wa3 got=%h exp=3", wa3); end
  endtask

  task automatic test_secondary();
    s_claim = 1; s_claim_ra = 4'd7;
    tick();
    clear_inputs();
    checks++; if (busy !== 15'h0080) begin failures++; $display("FAIL sec_claim_busy got=%h exp=0080", busy); end
    s_valid = 1; s_wa = 4'd7; s_wd = 32'h0000_0042;
    tick();
    clear_inputs();
    checks++; if (we3 !== 1'b0) begin failures++; $display("FAIL sec_cycle1_we3 got=%b exp=0", we3); end
    checks++; if (busy !== 15'h0080) begin failures++; $display("FAIL sec_cycle1_busy got=%h exp=0080", busy); end
    tick();
    checks++; if ({we3, wa3, wd3} !== {1'b1, 4'd7, 32'h42}) begin failures++; $display("FAIL sec_write got=%b/%h/%h exp=1/7/42", we3, wa3, wd3); end
    checks++; if (busy !== 15'h0000) begin failures++; $display("FAIL sec_busy_clear got=%h exp=0", busy); end
    tick();
    checks++; if (we3 !== 1'b0) begin failures++; $display("FAIL sec_after_we3 got=%b exp=0", we3); end
  endtask

  task automatic test_collision();
    s_valid = 1; s_wa = 4'd2; s_wd = 32'h22;
    tick();
    clear_inputs();
    p_we = 1; p_wa = 4'd1; p_wd = 32'h11;
    tick();
    clear_inputs();
    checks++; if ({we3, wa3, wd3} !== {1'b1, 4'd1, 32'h11}) begin failures++; $display("FAIL coll_primary got=%b/%h/%h exp=1/1/11", we3, wa3, wd3); end
    tick();
    checks++; if ({we3, wa3, wd3} !== {1'b1, 4'd2, 32'h22}) begin failures++; $display("FAIL coll_secondary got=%b/%h/%h exp=1/2/22", we3, wa3, wd3); end
    tick();
    checks++; if (we3 !== 1'b0) begin failures++; $display("FAIL coll_after_we3 got=%b exp=0", we3); end
  endtask

  task automatic test_starvation();
    s_valid = 1; s_wa = 4'd8; s_wd = 32'h80;
    tick();
    s_wa = 4'd9; s_wd = 32'h90;
    p_we = 1; p_wa = 4'd1; p_wd = 32'h1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL starve_early_stall cyc=%0d got=%b exp=0", i, stall_req); end
      end
      tick();
      s_valid = 0;
    end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL starve_full_ready got=%b exp=0", s_ready); end
    checks++; if (stall_req !== 1'b1) begin failures++; $display("FAIL starve_stall got=%b exp=1", stall_req); end
    clear_inputs();
    tick();
    checks++; if ({we3, wa3, wd3} !== {1'b1, 4'd8, 32'h80}) begin failures++; $display("FAIL starve_drain0 got=%b/%h/%h exp=1/8/80", we3, wa3, wd3); end
    checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL starve_stall_drop got=%b exp=0", stall_req); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL starve_ready got=%b exp=1", s_ready); end
    tick();
    checks++; if ({we3, wa3, wd3} !== {1'b1, 4'd9, 32'h90}) begin failures++; $display("FAIL starve_drain1 got=%b/%h/%h exp=1/9/90", we3, wa3, wd3); end
    tick();
    checks++; if (we3 !== 1'b0) begin failures++; $display("FAIL starve_after_we3 got=%b exp=0", we3); end
  endtask

  task automatic test_r15_scoreboard();
    p_we = 1; p_wa = 4'd15; p_wd = 32'hFFFF;
    s_claim = 1; s_claim_ra = 4'd15;
    tick();
    clear_inputs();
    checks++; if (we3 !== 1'b0) begin failures++; $display("FAIL r15_primary_we3 got=%b exp=0", we3); end
    checks++; if (busy !== 15'h0) begin failures++; $display("FAIL r15_claim_busy got=%h exp=0", busy); end
    s_claim = 1; s_claim_ra = 4'd5;
    tick();
    clear_inputs();
    checks++; if (busy !== 15'h0020) begin failures++; $display("FAIL claim5_busy got=%h exp=0020", busy); end
    p_we = 1; p_wa = 4'd5; p_wd = 32'h55;
    tick();
    clear_inputs();
    checks++; if (waw_err !== 1'b1) begin failures++; $display("FAIL waw_pulse got=%b exp=1", waw_err); end
    checks++; if ({we3, wa3} !== {1'b1, 4'd5}) begin failures++; $display("FAIL waw_write got=%b/%h exp=1/5", we3, wa3); end
    tick();
    checks++; if (waw_err !== 1'b0) begin failures++; $display("FAIL waw_clear got=%b exp=0", waw_err); end
    s_valid = 1; s_wa = 4'd5; s_wd = 32'h5005;
    tick();
    clear_inputs();
    s_claim = 1; s_claim_ra = 4'd5;
    tick();
    clear_inputs();
    checks++; if ({we3, wa3, wd3} !== {1'b1, 4'd5, 32'h5005}) begin failures++; $display("FAIL setwins_write got=%b/%h/%h exp=1/5/5005", we3, wa3, wd3); end
    checks++; if (busy !== 15'h0020) begin failures++; $display("FAIL setwins_busy got=%h exp=0020", busy); end
    s_valid = 1; s_wa = 4'd15; s_wd = 32'hDEAD;
    tick();
    clear_inputs();
    tick();
    checks++; if (we3 !== 1'b0) begin failures++; $display("FAIL r15_sec_we3 got=%b exp=0", we3); end
    checks++; if (wd3 !== 32'h5005) begin failures++; $display("FAIL r15_sec_hold_wd3 got=%h exp=5005", wd3); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL r15_sec_ready got=%b exp=1", s_ready); end
  endtask

  task automatic test_reset_mid();
    s_valid = 1; s_wa = 4'd10; s_wd = 32'hA;
    s_claim = 1; s_claim_ra = 4'd4;
    tick();
    s_claim = 0;
    s_wa = 4'd11; s_wd = 32'hB;
    p_we = 1; p_wa = 4'd2; p_wd = 32'h2;
    tick();
    s_valid = 0;
    tick();
    clear_inputs();
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL mid_full_ready got=%b exp=0", s_ready); end
    reset_n = 0;
    #1;
    checks++; if (we3 !== 1'b0) begin failures++; $display("FAIL mid_reset_we3 got=%b exp=0", we3); end
    checks++; if (busy !== 15'h0) begin failures++; $display("FAIL mid_reset_busy got=%h exp=0", busy); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_ready got=%b exp=1", s_ready); end
    checks++; if (wa3 !== 4'd0) begin failures++; $display("FAIL mid_reset_wa3 got=%h exp=0", wa3); end
    tick();
    tick();
    reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (we3 !== 1'b0) begin failures++; $display("FAIL mid_stale_we3 cyc=%0d got=%b exp=0", i, we3); end
    end
  endtask

  initial begin
    test_reset();
    test_primary();
    test_secondary();
    test_collision();
    test_starvation();
    test_r15_scoreboard();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
